// File: rtl/vga_sched_pkg.sv
// vga_sched_pkg
//   Shared definitions for the VGA pixel-buffer write scheduler.
//   - sched_state_t : frame sequencing states
//   - DEF_*         : default widths and sizes used by the scheduler top
//   - px_entry_t    : write-buffer entry {addr, color} at the default widths
//   - ptr_width()   : width of an index into N iterators (at least 1 bit)
package vga_sched_pkg;

  localparam int DEF_N          = 21;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARB,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] color;
  } px_entry_t;

  // A single iterator still needs a 1-bit pointer register.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_write_scheduler_fifo.sv
// px_write_fifo
//   Synchronous write buffer between the grant logic and the SRAM master.
//   The head entry is visible combinationally whenever the buffer is not empty.
//   Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2)
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset (empties the buffer)
//     push   in   write din at the tail (caller guarantees not full)
//     pop    in   drop the head entry (caller guarantees not empty)
//     din    in   entry to write
//     head   out  oldest entry
//     full   out  DEPTH entries held
//     empty  out  no entries held
module px_write_fifo
  import vga_sched_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vga_write_scheduler.sv
// vga_write_scheduler
//   Shares the single VGA pixel-buffer SRAM write port between N column
//   iterators. Launches a frame, grants one pending pixel per cycle in
//   round-robin order, buffers accepted pixels and drives a
//   waitrequest-aware SRAM master port. Signals frame completion once all
//   iterators are done and every buffered pixel has been written.
//   Optional feature macro: FRAME_TIMER_EN adds the frame_cycles counter.
//   Ports:
//     clk, reset (async active-low)
//     run              one-cycle frame start request (IDLE/DONE only)
//     req_valid/addr/color/done   per-iterator request bundle (packed)
//     req_ack          one-hot acceptance pulse
//     iter_start       one-cycle pulse starting all iterators
//     sram_address/writedata/write, sram_waitrequest   SRAM master port
//     frame_done       level, frame finished and drained
//     frame_cycles     ARB+DRAIN cycle count (FRAME_TIMER_EN only)
module vga_write_scheduler
  import vga_sched_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [N-1:0]        req_valid,
  input  logic [N*ADDR_W-1:0] req_addr,
  input  logic [N*DATA_W-1:0] req_color,
  input  logic [N-1:0]        req_done,
  output logic [N-1:0]        req_ack,
  output logic                iter_start,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic                sram_write,
  input  logic                sram_waitrequest,
  output logic                frame_done
`ifdef FRAME_TIMER_EN
  ,
  output logic [31:0]         frame_cycles
`endif
);

  localparam int PW = ptr_width(N);
  localparam int EW = ADDR_W + DATA_W;

  sched_state_t  state, state_next;
  logic [PW-1:0] rr_ptr;
  logic [N-1:0]  ack_q;
  logic [N-1:0]  eligible;
  logic [N-1:0]  grant_onehot;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          all_done;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] push_data, head;

  // The iterator acked last cycle still shows its old pixel, so it sits out
  // one cycle; the registered ack doubles as that cooldown mask.
  assign eligible = req_valid & ~ack_q;
  assign all_done = (&req_done) && (req_valid == '0);

  // Round-robin pick: first eligible index above the last winner, wrapping.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int off = 1; off <= N; off++) begin
      if (!grant_found && eligible[(int'(rr_ptr) + off) % N]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(rr_ptr) + off) % N);
        grant_onehot[(int'(rr_ptr) + off) % N] = 1'b1;
      end
    end
  end

  // A full buffer blocks the grant even if the head is popped this cycle.
  assign push      = (state == ARB) && !all_done && !fifo_full && grant_found;
  assign pop       = !fifo_empty && !sram_waitrequest;
  assign push_data = {req_addr[ADDR_W*grant_idx +: ADDR_W],
                      req_color[DATA_W*grant_idx +: DATA_W]};

  px_write_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head is held until the slave accepts it, so address/data stay
  // stable through waitrequest.
  assign sram_write     = !fifo_empty;
  assign sram_address   = fifo_empty ? '0 : head[EW-1:DATA_W];
  assign sram_writedata = fifo_empty ? '0 : head[DATA_W-1:0];
  assign req_ack        = ack_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= PW'(N - 1);
      ack_q  <= '0;
    end else begin
      state <= state_next;
      ack_q <= push ? grant_onehot : '0;
      if (push) rr_ptr <= grant_idx;
    end
  end

  always_comb begin
    state_next = state;
    iter_start = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  if (run) state_next = START;
      START: begin
        iter_start = 1'b1;
        state_next = ARB;
      end
      ARB:   if (all_done) state_next = DRAIN;
      DRAIN: if (fifo_empty) state_next = DONE;
      DONE: begin
        frame_done = 1'b1;
        if (run) state_next = START;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FRAME_TIMER_EN
  // Cleared on the way into ARB, then counts every ARB/DRAIN cycle and
  // holds its final value through DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cycles <= '0;
    end else if (state == START) begin
      frame_cycles <= '0;
    end else if ((state == ARB || state == DRAIN) && frame_cycles != 32'hFFFF_FFFF) begin
      frame_cycles <= frame_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_write_scheduler.sv
// tb_vga_write_scheduler
//   Self-checking bench for vga_write_scheduler. A queue-based reference
//   model tracks the expected buffer contents, grant order and frame phase;
//   directed table vectors and hand-written sequences cover arbitration
//   order, cooldown, back-pressure, drain and mid-frame reset, followed by
//   randomized frames.
module tb_vga_write_scheduler;

  localparam int N      = 21;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int EW     = ADDR_W + DATA_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                run;
  logic [N-1:0]        req_valid;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N*DATA_W-1:0] req_color;
  logic [N-1:0]        req_done;
  logic [N-1:0]        req_ack;
  logic                iter_start;
  logic [ADDR_W-1:0]   sram_address;
  logic [DATA_W-1:0]   sram_writedata;
  logic                sram_write;
  logic                sram_waitrequest;
  logic                frame_done;
`ifdef FRAME_TIMER_EN
  logic [31:0]         frame_cycles;
`endif

  always #5 clk = ~clk;

  vga_write_scheduler #(
    .N          (N),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_color        (req_color),
    .req_done         (req_done),
    .req_ack          (req_ack),
    .iter_start       (iter_start),
    .sram_address     (sram_address),
    .sram_writedata   (sram_writedata),
    .sram_write       (sram_write),
    .sram_waitrequest (sram_waitrequest),
    .frame_done       (frame_done)
`ifdef FRAME_TIMER_EN
    ,
    .frame_cycles     (frame_cycles)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: frame phase, pending-pixel queue, last winner,
  // iterator acked in the current cycle, elapsed frame cycles.
  typedef enum int {P_IDLE, P_START, P_ARB, P_DRAIN, P_DONE} phase_t;
  phase_t        m_phase;
  logic [EW-1:0] m_q[$];
  int            m_last;
  int            m_ack;
  longint        m_timer;
  int            it_rem[N];
  int            it_adv;

  typedef struct {
    logic [N-1:0] mask;
    int           winner;
  } vec_t;
  vec_t tbl[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N-1:0] d, input logic w);
    run              = r;
    req_valid        = v;
    req_done         = d;
    sram_waitrequest = w;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic modelReset();
    m_phase = P_IDLE;
    m_q.delete();
    m_last  = N - 1;
    m_ack   = -1;
    m_timer = 0;
    it_adv  = -1;
  endtask

  task automatic compareAll();
    logic [EW-1:0] h;
    checkOutput("req_ack", req_ack, onehot(m_ack));
    checkOutput("iter_start", iter_start, m_phase == P_START);
    checkOutput("frame_done", frame_done, m_phase == P_DONE);
    checkOutput("sram_write", sram_write, m_q.size() > 0);
    if (m_q.size() > 0) begin
      h = m_q[0];
      checkOutput("sram_address", sram_address, h[EW-1:DATA_W]);
      checkOutput("sram_writedata", sram_writedata, h[DATA_W-1:0]);
    end
`ifdef FRAME_TIMER_EN
    checkOutput("frame_cycles", frame_cycles, m_timer);
`endif
  endtask

  // Decide what the coming clock edge does, from the inputs now applied.
  task automatic modelAdvance();
    int grant;
    bit pop;
    int size_now;
    grant    = -1;
    size_now = m_q.size();
    pop      = (size_now > 0) && !sram_waitrequest;
    it_adv   = m_ack;
    if (m_phase == P_START) m_timer = 0;
    else if ((m_phase == P_ARB || m_phase == P_DRAIN) && m_timer < 64'hFFFF_FFFF) m_timer++;
    case (m_phase)
      P_IDLE, P_DONE: if (run) m_phase = P_START;
      P_START:        m_phase = P_ARB;
      P_ARB: begin
        if ((&req_done) && req_valid == '0) m_phase = P_DRAIN;
        else if (size_now < DEPTH) begin
          for (int j = 1; j <= N; j++) begin
            int idx;
            idx = (m_last + j) % N;
            if (grant < 0 && req_valid[idx] && idx != m_ack) grant = idx;
          end
        end
      end
      P_DRAIN:        if (size_now == 0) m_phase = P_DONE;
      default:        m_phase = P_IDLE;
    endcase
    if (pop) void'(m_q.pop_front());
    if (grant >= 0) begin
      m_q.push_back({req_addr[ADDR_W*grant +: ADDR_W], req_color[DATA_W*grant +: DATA_W]});
      m_last = grant;
    end
    m_ack = grant;
  endtask

  // One clock: compare at the falling edge, then settle 1 time unit past the rising edge.
  task automatic step();
    @(negedge clk);
    compareAll();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    reset = 1'b1;
  endtask

  task automatic setPixel(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] c);
    req_addr[ADDR_W*i +: ADDR_W]  = a;
    req_color[DATA_W*i +: DATA_W] = c;
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, '0, '0, 1'b0);
    step();
    run = 1'b0;
    step();
  endtask

  task automatic randomFrame();
    int cyc;
    for (int i = 0; i < N; i++) begin
      it_rem[i] = $urandom_range(0, 3);
      setPixel(i, $urandom, DATA_W'($urandom));
    end
    it_adv = -1;
    applyStimulus(1'b1, '0, '0, 1'b0);
    cyc = 0;
    while (m_phase != P_DONE && cyc < 3000) begin
      if (it_adv >= 0 && it_rem[it_adv] > 0) begin
        it_rem[it_adv]--;
        setPixel(it_adv, $urandom, DATA_W'($urandom));
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (it_rem[i] > 0) && ($urandom_range(0, 3) != 0);
        req_done[i]  = (it_rem[i] == 0);
      end
      sram_waitrequest = ($urandom_range(0, 2) == 0);
      if (cyc > 0) run = ($urandom_range(0, 15) == 0);
      step();
      cyc++;
    end
    checkOutput("frame_completes", m_phase == P_DONE, 1'b1);
    run = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks, b2b;
    logic prev;

    tbl[0]  = '{21'h100021, 0};
    tbl[1]  = '{21'h100021, 5};
    tbl[2]  = '{21'h100021, 20};
    tbl[3]  = '{21'h100021, 0};
    tbl[4]  = '{21'h100000, 20};
    tbl[5]  = '{21'h080008, 3};
    tbl[6]  = '{21'h000006, 1};
    tbl[7]  = '{21'h000002, 1};
    tbl[8]  = '{21'h1FFFFF, 2};
    tbl[9]  = '{21'h100001, 20};
    tbl[10] = '{21'h100001, 0};

    req_addr  = '0;
    req_color = '0;
    doReset();

    // Frame launch: iter_start one edge after run, for one cycle only.
    applyStimulus(1'b1, '0, '0, 1'b0);
    step();
    checkOutput("iter_start_after_run", iter_start, 1'b1);
    run = 1'b0;
    step();
    checkOutput("iter_start_one_cycle", iter_start, 1'b0);

    // Round-robin order vectors, with an idle cycle between entries.
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < N; i++) setPixel(i, 32'h1000 + i*16 + v, DATA_W'(i + v));
      applyStimulus(1'b0, tbl[v].mask, '0, 1'b0);
      step();
      checkOutput("tbl_ack", req_ack, onehot(tbl[v].winner));
      checkOutput("tbl_addr", sram_address, 32'h1000 + tbl[v].winner*16 + v);
      applyStimulus(1'b0, '0, '0, 1'b0);
      step();
    end

    // Single requester held continuously: acked every second cycle.
    acks = 0; b2b = 0; prev = 1'b0;
    applyStimulus(1'b0, onehot(3), '0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (req_ack[3]) begin
        acks++;
        if (prev) b2b++;
      end
      prev = req_ack[3];
    end
    checkOutput("single_ack_count", acks, 6);
    checkOutput("single_back_to_back", b2b, 0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) step();

    // Back-pressure: buffer fills to DEPTH, head held stable, then drains in order.
    doReset();
    startFrame();
    for (int i = 0; i < N; i++) setPixel(i, 32'h2000 + i, DATA_W'(8'h40 + i));
    applyStimulus(1'b0, 21'h0000FF, '0, 1'b1);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req_ack != '0) acks++;
      checkOutput("wait_addr_stable", sram_address, 32'h2000);
    end
    checkOutput("wait_ack_count", acks, DEPTH);
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("drain_order", sram_address, 32'h2000 + k);
      step();
    end
    checkOutput("drain_empty", sram_write, 1'b0);

    // Completion waits for buffered writes to finish.
    applyStimulus(1'b0, 21'h000003, '0, 1'b1);
    repeat (2) step();
    applyStimulus(1'b0, '0, '1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("done_held_by_wait", frame_done, 1'b0);
    end
    applyStimulus(1'b0, '0, '1, 1'b0);
    repeat (2) step();
    checkOutput("done_not_early", frame_done, 1'b0);
    step();
    checkOutput("done_after_drain", frame_done, 1'b1);
    step();

    // Reset mid-frame with pixels buffered and an ack in flight.
    doReset();
    startFrame();
    applyStimulus(1'b0, 21'h000007, '0, 1'b1);
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_sram_write", sram_write, 1'b0);
    checkOutput("rst_req_ack", req_ack, '0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_iter_start", iter_start, 1'b0);
    modelReset();
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    step();
    checkOutput("post_rst_empty", sram_write, 1'b0);
    applyStimulus(1'b1, '0, '0, 1'b0);
    step();
    checkOutput("post_rst_idle_start", iter_start, 1'b1);
    run = 1'b0;

    // Randomized frames against the model.
    for (int f = 0; f < 4; f++) randomFrame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
